// File: rtl/jtframe_dwnld_buf.sv
// ioctl byte-stream to SDRAM programming-port bridge with a small write FIFO.
// Optional JTFRAME_DWNLD_BANK_EN: ioctl_addr[24:23] selects prog_bank; otherwise bank is 0.
module jtframe_dwnld_buf #(
  parameter int unsigned AW          = 2,
  parameter int unsigned POST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        dwnld_busy,
  output logic        ovf
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PW    = AW + 1;
`ifdef JTFRAME_DWNLD_BANK_EN
  localparam int unsigned AB    = 25;
`else
  localparam int unsigned AB    = 23;
`endif
  localparam int unsigned EW    = AB + 8;
  localparam logic [7:0]  POST_LD = 8'(POST_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nx, rd_nx;
  logic [0:0]    state, state_nx;
  logic [7:0]    post_cnt, post_nx;
  logic          empty, full, push, drop, pop, active;
  logic          we_nx, busy_nx, dl_l;
  logic [EW-1:0] head;
  logic [AB-1:0] head_addr;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push      = ioctl_wr & downloading & ~full;
  assign drop      = ioctl_wr & downloading & full;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_addr = head[EW-1:8];

  // Entry storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ioctl_addr[AB-1:0], ioctl_data};
  end

  // Next-state, pointer and busy-extension logic
  always_comb begin
    state_nx = state;
    we_nx    = prog_we;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          we_nx    = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (prog_rdy) begin
          we_nx    = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        we_nx    = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase

    wr_nx   = push ? wr_ptr + PW'(1) : wr_ptr;
    rd_nx   = pop  ? rd_ptr + PW'(1) : rd_ptr;
    active  = downloading | ~empty | (state == ST_WAIT);
    post_nx = active ? POST_LD : ((post_cnt != 8'd0) ? post_cnt - 8'd1 : 8'd0);
    // Busy is registered, so it is computed from the values the state takes next
    busy_nx = downloading | (wr_nx != rd_nx) | (state_nx == ST_WAIT) | (post_nx != 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= 8'd0;
      prog_we    <= 1'b0;
      prog_addr  <= 22'd0;
      prog_data  <= 8'd0;
      prog_mask  <= 2'b11;
      dwnld_busy <= 1'b0;
      ovf        <= 1'b0;
      dl_l       <= 1'b0;
    end else begin
      state      <= state_nx;
      wr_ptr     <= wr_nx;
      rd_ptr     <= rd_nx;
      post_cnt   <= post_nx;
      prog_we    <= we_nx;
      dwnld_busy <= busy_nx;
      dl_l       <= downloading;
      if (drop) ovf <= 1'b1;
      else if (downloading & ~dl_l) ovf <= 1'b0;
      if (pop) begin
        prog_addr <= head_addr[22:1];
        prog_data <= head[7:0];
        prog_mask <= head_addr[0] ? 2'b01 : 2'b10;
      end
    end
  end

`ifdef JTFRAME_DWNLD_BANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prog_bank <= 2'b00;
    else if (pop) prog_bank <= head_addr[24:23];
  end
`else
  logic unused_bank_bits;
  assign unused_bank_bits = ^ioctl_addr[24:23];
  assign prog_bank = 2'b00;
`endif

endmodule

// File: tb/tb_jtframe_dwnld_buf.sv
// Self-checking bench for jtframe_dwnld_buf: queue-based reference model plus directed literal checks.
module tb_jtframe_dwnld_buf;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned POST  = 16;

  logic        clk = 1'b0, rst_n = 1'b1, downloading = 1'b0, ioctl_wr = 1'b0, prog_rdy = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask, prog_bank;
  logic        prog_we, dwnld_busy, ovf;

  int tests = 0, fails = 0;

  jtframe_dwnld_buf #(.AW(AW), .POST_CYCLES(POST)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_bank(prog_bank), .prog_we(prog_we), .prog_rdy(prog_rdy),
    .dwnld_busy(dwnld_busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending bytes plus the one write being offered
  typedef struct packed { logic [24:0] a; logic [7:0] d; } ent_t;
  ent_t        q[$];
  logic        m_we = 1'b0, m_ovf = 1'b0, m_busy = 1'b0, m_dl = 1'b0;
  logic [21:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [1:0]  m_mask = 2'b11, m_bank = 2'b00;
  int          cyc = 0, last_act = -1000;

  always @(posedge clk or negedge rst_n) begin : model
    int   sz;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_we = 1'b0; m_ovf = 1'b0; m_busy = 1'b0; m_dl = 1'b0;
      m_addr = '0; m_data = '0; m_mask = 2'b11; m_bank = 2'b00;
      last_act = -1000;
    end else begin
      sz = q.size();
      if (downloading || sz != 0 || m_we) last_act = cyc;
      if (m_we) begin
        if (prog_rdy) m_we = 1'b0;
      end else if (sz != 0) begin
        e      = q.pop_front();
        m_we   = 1'b1;
        m_addr = e.a[22:1];
        m_data = e.d;
        m_mask = e.a[0] ? 2'b01 : 2'b10;
`ifdef JTFRAME_DWNLD_BANK_EN
        m_bank = e.a[24:23];
`else
        m_bank = 2'b00;
`endif
      end
      if (downloading && !m_dl) m_ovf = 1'b0;
      if (ioctl_wr && downloading) begin
        if (sz == DEPTH) m_ovf = 1'b1;
        else begin
          e.a = ioctl_addr;
          e.d = ioctl_data;
          q.push_back(e);
        end
      end
      m_busy = downloading || (q.size() != 0) || m_we || ((cyc + 1 - last_act) <= POST);
      m_dl   = downloading;
      cyc++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("we",   32'(prog_we),    32'(m_we));
    chk("addr", 32'(prog_addr),  32'(m_addr));
    chk("data", 32'(prog_data),  32'(m_data));
    chk("mask", 32'(prog_mask),  32'(m_mask));
    chk("bank", 32'(prog_bank),  32'(m_bank));
    chk("busy", 32'(dwnld_busy), 32'(m_busy));
    chk("ovf",  32'(ovf),        32'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_we();
    int k = 0;
    while (!prog_we && k < 30) begin
      tick();
      k++;
    end
    chk("wait_we_timeout", 32'(prog_we), 32'd1);
  endtask

  task automatic pulse_rdy();
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
    chk("we_low_after_rdy", 32'(prog_we), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int       k;
    logic [1:0] exp_bank;
    logic [24:0] a;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_we",   32'(prog_we),    32'd0);
    chk("rst_mask", 32'(prog_mask),  32'd3);
    chk("rst_addr", 32'(prog_addr),  32'd0);
    chk("rst_busy", 32'(dwnld_busy), 32'd0);
    chk("rst_ovf",  32'(ovf),        32'd0);

    // Single byte: latency and mapping
    downloading = 1'b1;
    tick();
    wr(25'h000005, 8'hA5);
    chk("single_we_n1", 32'(prog_we), 32'd0);
    tick();
    chk("single_we_n2", 32'(prog_we),   32'd1);
    chk("single_addr",  32'(prog_addr), 32'h2);
    chk("single_mask",  32'(prog_mask), 32'h1);
    chk("single_data",  32'(prog_data), 32'hA5);
    tick();
    tick();
    pulse_rdy();

    // Burst of four, drained by single rdy pulses
    for (int i = 0; i < 4; i++) wr(25'(i), 8'(8'h10 + i));
    tick();
    tick();
    chk("burst_no_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_we();
      chk("burst_addr", 32'(prog_addr), 32'(i >> 1));
      chk("burst_mask", 32'(prog_mask), ((i & 1) != 0) ? 32'h1 : 32'h2);
      chk("burst_data", 32'(prog_data), 32'(8'h10 + i));
      pulse_rdy();
    end

    // Overflow: one entry in flight plus four buffered, sixth byte dropped
    tick();
    for (int i = 0; i < 6; i++) wr(25'(32'h20 + i), 8'(8'h30 + i));
    chk("ovf_set", 32'(ovf), 32'd1);
    downloading = 1'b0;
    repeat (3) tick();
    chk("ovf_sticky", 32'(ovf), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_we();
      if (i == 4) begin
        chk("ovf_last_addr", 32'(prog_addr), 32'h12);
        chk("ovf_last_data", 32'(prog_data), 32'h34);
      end
      pulse_rdy();
    end
    repeat (3) tick();
    chk("ovf_no_extra_we", 32'(prog_we), 32'd0);
    downloading = 1'b1;
    tick();
    chk("ovf_clear_on_rise", 32'(ovf), 32'd0);

    // Busy extension after the last write is accepted
    wr(25'h000040, 8'h77);
    downloading = 1'b0;
    wait_we();
    tick();
    tick();
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
    k = 0;
    while (dwnld_busy && k < 40) begin
      tick();
      k++;
    end
    chk("busy_tail_cycles", 32'(k), 32'd16);

    // Bank mapping
    downloading = 1'b1;
    a = 25'h0800001;
`ifdef JTFRAME_DWNLD_BANK_EN
    exp_bank = 2'b01;
`else
    exp_bank = 2'b00;
`endif
    wr(a, 8'h5A);
    wait_we();
    chk("bank_addr", 32'(prog_addr), 32'h0);
    chk("bank_bank", 32'(prog_bank), 32'(exp_bank));
    chk("bank_mask", 32'(prog_mask), 32'h1);
    pulse_rdy();

    // Asynchronous reset with a write pending and entries queued
    tick();
    for (int i = 0; i < 7; i++) wr(25'(32'h100 + i), 8'(i));
    chk("pre_rst_we",  32'(prog_we), 32'd1);
    chk("pre_rst_ovf", 32'(ovf),     32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_we",   32'(prog_we),    32'd0);
    chk("async_rst_busy", 32'(dwnld_busy), 32'd0);
    chk("async_rst_ovf",  32'(ovf),        32'd0);
    downloading = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_we",   32'(prog_we),    32'd0);
    chk("post_rst_busy", 32'(dwnld_busy), 32'd0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
